fp32_norm_round: RTL

FP32_NORM_ROUND -- requirements
Module: fp32_norm_round

---
 rtl/fp_pkg.sv | 16 +
 rtl/norm_lshift.sv | 46 ++++
 rtl/fp32_norm_round.sv | 164 ++++++++++++++++
 3 files changed

// File: rtl/fp_pkg.sv
// Shared widths, exponent limits and flag bit positions for the fp32
// normalise/round datapath.
package fp_pkg;

  localparam int unsigned MANT_W  = 28;
  localparam int unsigned EXP_W   = 10;
  localparam int unsigned BIAS    = 127;
  localparam int unsigned EXP_MAX = 255;

  localparam int unsigned FLAG_OVF = 2;
  localparam int unsigned FLAG_UNF = 1;
  localparam int unsigned FLAG_INX = 0;

  typedef logic [3:0] lza_code_t;

endpackage

// File: rtl/norm_lshift.sv
// Decodes the three one-hot LZA fields into a shift amount and left-shifts
// the raw mantissa by it. Purely combinational.
module norm_lshift #(
  parameter int unsigned W = fp_pkg::MANT_W
) (
  input  logic [2:0][3:0] shift_code,
  input  logic [W-1:0]    mant,
  output logic [4:0]      amount,
  output logic [W-1:0]    shifted
);
  import fp_pkg::*;

  lza_code_t code_hi, code_mid, code_lo;
  logic [4:0] amt_hi, amt_mid, amt_lo;

  assign code_hi  = shift_code[2];
  assign code_mid = shift_code[1];
  assign code_lo  = shift_code[0];

  // Anything that is not one of the listed one-hot codes contributes nothing.
  always_comb begin
    amt_hi  = '0;
    amt_mid = '0;
    amt_lo  = '0;
    case (code_hi)
      4'b0010: amt_hi = 5'd16;
      default: amt_hi = '0;
    endcase
    case (code_mid)
      4'b0010: amt_mid = 5'd4;
      4'b0100: amt_mid = 5'd8;
      4'b1000: amt_mid = 5'd12;
      default: amt_mid = '0;
    endcase
    case (code_lo)
      4'b0010: amt_lo = 5'd1;
      4'b0100: amt_lo = 5'd2;
      4'b1000: amt_lo = 5'd3;
      default: amt_lo = '0;
    endcase
  end

  assign amount  = amt_hi + amt_mid + amt_lo;
  assign shifted = mant << amount;

endmodule

// File: rtl/fp32_norm_round.sv
// Three-stage normalise / round-to-nearest-even / pack pipeline producing an
// IEEE-754 binary32 result with {overflow, underflow, inexact} flags.
module fp32_norm_round #(
  parameter int unsigned MANT_W = fp_pkg::MANT_W,
  parameter int unsigned EXP_W  = fp_pkg::EXP_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              in_sign,
  input  logic [EXP_W-1:0]  in_exp,
  input  logic [MANT_W-1:0] in_mant,
  input  logic [2:0][3:0]   in_shift,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [31:0]       out_result,
  output logic [2:0]        out_flags
);
  import fp_pkg::*;

  // Two extra exponent bits absorb the +1 / -31 / -1 / +1 adjustments.
  localparam int unsigned XW = EXP_W + 2;
  localparam int unsigned SW = MANT_W - 4;
  localparam logic signed [XW-1:0] EXP_TOP  = XW'(EXP_MAX);
  localparam logic signed [XW-1:0] EXP_ZERO = '0;

  logic enable;
  assign enable   = ~out_valid | out_ready;
  assign in_ready = enable;

  // Stage 1: coarse normalisation
  logic [4:0]              lza_amt;
  logic [MANT_W-1:0]       lza_mant;
  logic signed [XW-1:0]    exp_in;
  logic [MANT_W-1:0]       s1_mant_d;
  logic signed [XW-1:0]    s1_exp_d;

  norm_lshift #(.W(MANT_W)) u_lshift (
    .shift_code (in_shift),
    .mant       (in_mant),
    .amount     (lza_amt),
    .shifted    (lza_mant)
  );

  assign exp_in = {{2{in_exp[EXP_W-1]}}, in_exp};

  always_comb begin
    s1_mant_d = lza_mant;
    s1_exp_d  = exp_in - XW'(lza_amt);
    if (in_mant[MANT_W-1]) begin
      s1_mant_d = {1'b0, in_mant[MANT_W-1:2], |in_mant[1:0]};
      s1_exp_d  = exp_in + XW'(1);
    end
  end

  logic                 s1_valid, s1_sign, s1_zero;
  logic [MANT_W-1:0]    s1_mant;
  logic signed [XW-1:0] s1_exp;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_sign  <= 1'b0;
      s1_zero  <= 1'b0;
      s1_mant  <= '0;
      s1_exp   <= '0;
    end else if (enable) begin
      s1_valid <= in_valid;
      s1_sign  <= in_sign;
      s1_zero  <= (in_mant == '0);
      s1_mant  <= s1_mant_d;
      s1_exp   <= s1_exp_d;
    end
  end

  // Stage 2: one-bit LZA correction and rounding decision
  logic [MANT_W-2:0]    s2_norm;
  logic signed [XW-1:0] s2_exp_d;
  logic                 guard, sticky, lsb;

  always_comb begin
    s2_norm  = s1_mant[MANT_W-2:0];
    s2_exp_d = s1_exp;
    if (!s1_mant[MANT_W-2] && (s1_mant != '0)) begin
      s2_norm  = {s1_mant[MANT_W-3:0], 1'b0};
      s2_exp_d = s1_exp - XW'(1);
    end
  end

  assign guard  = s2_norm[2];
  assign sticky = |s2_norm[1:0];
  assign lsb    = s2_norm[3];

  logic                 s2_valid, s2_sign, s2_zero, s2_inc, s2_inx;
  logic [SW-1:0]        s2_sig;
  logic signed [XW-1:0] s2_exp;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s2_valid <= 1'b0;
      s2_sign  <= 1'b0;
      s2_zero  <= 1'b0;
      s2_inc   <= 1'b0;
      s2_inx   <= 1'b0;
      s2_sig   <= '0;
      s2_exp   <= '0;
    end else if (enable) begin
      s2_valid <= s1_valid;
      s2_sign  <= s1_sign;
      s2_zero  <= s1_zero;
      s2_inc   <= guard & (sticky | lsb);
      s2_inx   <= guard | sticky;
      s2_sig   <= s2_norm[MANT_W-2:3];
      s2_exp   <= s2_exp_d;
    end
  end

  // Stage 3: increment, renormalise, range check and pack
  logic [SW:0]          rnd_sum;
  logic [SW-2:0]        frac;
  logic signed [XW-1:0] exp_fin;
  logic                 unused_hidden;
  logic [31:0]          res_d;
  logic [2:0]           flags_d;

  // A carry-out leaves the low bits all zero, so the fraction needs no mux.
  assign rnd_sum       = {1'b0, s2_sig} + (SW+1)'(s2_inc);
  assign frac          = rnd_sum[SW-2:0];
  assign unused_hidden = rnd_sum[SW-1];
  assign exp_fin       = rnd_sum[SW] ? s2_exp + XW'(1) : s2_exp;

  always_comb begin
    res_d   = '0;
    flags_d = '0;
    if (s2_zero) begin
      res_d = {s2_sign, 31'b0};
    end else if (exp_fin >= EXP_TOP) begin
      res_d             = {s2_sign, 8'hFF, 23'b0};
      flags_d[FLAG_OVF] = 1'b1;
      flags_d[FLAG_INX] = 1'b1;
    end else if (exp_fin <= EXP_ZERO) begin
      res_d             = {s2_sign, 31'b0};
      flags_d[FLAG_UNF] = 1'b1;
      flags_d[FLAG_INX] = 1'b1;
    end else begin
      res_d             = {s2_sign, exp_fin[7:0], frac};
      flags_d[FLAG_INX] = s2_inx;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid  <= 1'b0;
      out_result <= '0;
      out_flags  <= '0;
    end else if (enable) begin
      out_valid  <= s2_valid;
      out_result <= res_d;
      out_flags  <= flags_d;
    end
  end

endmodule
